// File: rtl/reflet_alarm_scheduler.sv
// Multi-channel alarm scheduler ticked by a reflet timer interrupt; one shared decrementer scans channels in turn.
// Optional per-channel one-shot mode is enabled by defining REFLET_ALARM_ONESHOT_EN.
module reflet_alarm_scheduler #(
    parameter int                        wordsize       = 16,
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF20,
    parameter int                        CHANNELS       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic                      tick,
    output logic                      interrupt
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                backlog_q, backlog_d;
    logic                overrun_q, overrun_d;
    logic                irq_q, irq_d;
    logic [CHANNELS-1:0] ctrl_q, ctrl_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [7:0]          reload_q [CHANNELS];
    logic [7:0]          reload_d [CHANNELS];
    logic [7:0]          count_q [CHANNELS];
    logic [7:0]          count_d [CHANNELS];
`ifdef REFLET_ALARM_ONESHOT_EN
    logic [CHANNELS-1:0] oneshot_q, oneshot_d;
    logic                wr_oneshot;
`endif

    logic [base_addr_size-1:0] off;
    logic                      wr;
    logic                      wr_ctrl;
    logic                      wr_status;
    logic [CHANNELS-1:0]       wr_reload;
    logic [7:0]                rd;

    assign off       = addr - base_addr;
    assign wr        = enable & write_en;
    assign wr_ctrl   = wr && (off == base_addr_size'(0));
    assign wr_status = wr && (off == base_addr_size'(1));
`ifdef REFLET_ALARM_ONESHOT_EN
    assign wr_oneshot = wr && (off == base_addr_size'(2 + CHANNELS));
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            wr_reload[i] = wr && (off == base_addr_size'(2 + i));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        backlog_d = backlog_q;
        overrun_d = overrun_q;
        ctrl_d    = ctrl_q;
        pend_d    = pend_q;
        reload_d  = reload_q;
        count_d   = count_q;
`ifdef REFLET_ALARM_ONESHOT_EN
        oneshot_d = oneshot_q;
`endif
        irq_d     = |pend_q;

        if (wr_ctrl) begin
            ctrl_d = data_in[CHANNELS-1:0];
            for (int i = 0; i < CHANNELS; i++)
                if (data_in[i] && !ctrl_q[i]) count_d[i] = reload_q[i];
        end
        if (wr_status) begin
            pend_d = pend_q & ~data_in[CHANNELS-1:0];
            if (data_in[7]) overrun_d = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_reload[i]) begin
                reload_d[i] = data_in[7:0];
                count_d[i]  = data_in[7:0];
            end
        end
`ifdef REFLET_ALARM_ONESHOT_EN
        if (wr_oneshot) oneshot_d = data_in[CHANNELS-1:0];
`endif

        // Hardware set comes after the software clear so it wins; a bus write to the channel suppresses service.
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q == SCAN && idx_q == 3'(i) && ctrl_q[i] && reload_q[i] != 8'd0
                && !wr_ctrl && !wr_reload[i]) begin
                if (count_q[i] == 8'd1) begin
                    pend_d[i]  = 1'b1;
                    count_d[i] = reload_q[i];
`ifdef REFLET_ALARM_ONESHOT_EN
                    if (oneshot_q[i]) ctrl_d[i] = 1'b0;
`endif
                end else begin
                    count_d[i] = count_q[i] - 8'd1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (tick || backlog_q) begin
                    state_d   = SCAN;
                    idx_d     = 3'd0;
                    backlog_d = backlog_q & tick;
                end
            end
            SCAN: begin
                if (tick) begin
                    if (backlog_q) overrun_d = 1'b1;
                    else           backlog_d = 1'b1;
                end
                if (idx_q == 3'(CHANNELS - 1)) state_d = IDLE;
                else                           idx_d   = idx_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            backlog_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            ctrl_q    <= '0;
            pend_q    <= '0;
`ifdef REFLET_ALARM_ONESHOT_EN
            oneshot_q <= '0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                reload_q[i] <= 8'd0;
                count_q[i]  <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            backlog_q <= backlog_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
`ifdef REFLET_ALARM_ONESHOT_EN
            oneshot_q <= oneshot_d;
`endif
            reload_q  <= reload_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        rd = 8'd0;
        if (enable) begin
            if (off == base_addr_size'(0)) begin
                rd[CHANNELS-1:0] = ctrl_q;
            end else if (off == base_addr_size'(1)) begin
                rd[CHANNELS-1:0] = pend_q;
                rd[7]            = overrun_q;
            end
`ifdef REFLET_ALARM_ONESHOT_EN
            if (off == base_addr_size'(2 + CHANNELS)) rd[CHANNELS-1:0] = oneshot_q;
`endif
            for (int i = 0; i < CHANNELS; i++)
                if (off == base_addr_size'(2 + i)) rd = reload_q[i];
        end
    end

    assign data_out  = wordsize'(rd);
    assign interrupt = irq_q;

    generate
        if (wordsize > 8) begin : g_upper
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[wordsize-1:8];
        end
    endgenerate

endmodule

// File: tb/tb_reflet_alarm_scheduler.sv
// Directed bench for reflet_alarm_scheduler (CHANNELS=4, base 0xFF20); expected values are hand-derived.
module tb_reflet_alarm_scheduler;

    localparam logic [15:0] BASE = 16'hFF20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        write_en = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] data_out;
    logic        interrupt;

    int checks = 0;
    int passed = 0;

    reflet_alarm_scheduler #(
        .wordsize(16), .base_addr_size(16), .base_addr(16'hFF20), .CHANNELS(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .tick(tick), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic wr_reg(input int off, input logic [15:0] val);
        addr = BASE + 16'(off);
        data_in = val;
        enable = 1'b1;
        write_en = 1'b1;
        cyc(1);
        enable = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd_reg(input int off, output logic [15:0] v);
        addr = BASE + 16'(off);
        enable = 1'b1;
        write_en = 1'b0;
        #1;
        v = data_out;
        enable = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        do_reset();
        for (int o = 0; o < 8; o++) begin
            rd_reg(o, v);
            checks++;
            if (v !== 16'h0) $display("FAIL reset_read off=%0d got %h want 0000", o, v);
            else passed++;
        end
        checks++;
        if (interrupt !== 1'b0) $display("FAIL reset_irq got %b want 0", interrupt);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            cyc(8);
        end
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0) $display("FAIL reset_ticks_status got %h want 0000", v);
        else passed++;
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        logic        exp;
        do_reset();
        wr_reg(2, 16'h0003);
        wr_reg(0, 16'h0001);
        rd_reg(2, v);
        checks++;
        if (v !== 16'h0003) $display("FAIL periodic_reload_rd got %h want 0003", v);
        else passed++;
        rd_reg(0, v);
        checks++;
        if (v !== 16'h0001) $display("FAIL periodic_ctrl_rd got %h want 0001", v);
        else passed++;
        for (int k = 1; k <= 9; k++) begin
            exp = (k % 3 == 0);
            pulse_tick();
            cyc(1);
            rd_reg(1, v);
            checks++;
            if (v !== {15'h0, exp}) $display("FAIL periodic_status tick=%0d got %h want %h", k, v, {15'h0, exp});
            else passed++;
            checks++;
            if (interrupt !== 1'b0) $display("FAIL periodic_irq_early tick=%0d got %b want 0", k, interrupt);
            else passed++;
            cyc(1);
            checks++;
            if (interrupt !== exp) $display("FAIL periodic_irq tick=%0d got %b want %b", k, interrupt, exp);
            else passed++;
            if (exp) begin
                wr_reg(1, 16'h0001);
                rd_reg(1, v);
                checks++;
                if (v !== 16'h0) $display("FAIL periodic_clear tick=%0d got %h want 0000", k, v);
                else passed++;
                cyc(1);
                checks++;
                if (interrupt !== 1'b0) $display("FAIL periodic_irq_fall tick=%0d got %b want 0", k, interrupt);
                else passed++;
            end
            cyc(14);
        end
    endtask

    task automatic test_multi();
        logic [15:0] v;
        logic [15:0] exp;
        do_reset();
        wr_reg(3, 16'h0001);
        wr_reg(4, 16'h0002);
        wr_reg(0, 16'h000F);
        for (int k = 1; k <= 4; k++) begin
            exp = (k % 2 == 0) ? 16'h0006 : 16'h0002;
            pulse_tick();
            cyc(8);
            rd_reg(1, v);
            checks++;
            if (v !== exp) $display("FAIL multi_status tick=%0d got %h want %h", k, v, exp);
            else passed++;
            wr_reg(1, 16'h00FF);
            cyc(2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        do_reset();
        wr_reg(2, 16'h0001);
        wr_reg(0, 16'h0001);
        pulse_tick();
        cyc(1);
        pulse_tick();
        wr_reg(1, 16'h0001);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0) $display("FAIL b2b_after_clear got %h want 0000", v);
        else passed++;
        cyc(2);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0) $display("FAIL b2b_before_rescan got %h want 0000", v);
        else passed++;
        cyc(1);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0001) $display("FAIL b2b_rescan got %h want 0001", v);
        else passed++;
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        do_reset();
        wr_reg(2, 16'h0003);
        wr_reg(0, 16'h0001);
        tick = 1'b1;
        cyc(3);
        tick = 1'b0;
        cyc(12);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0080) $display("FAIL overrun_set got %h want 0080", v);
        else passed++;
        pulse_tick();
        cyc(6);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0081) $display("FAIL overrun_lost_tick got %h want 0081", v);
        else passed++;
        wr_reg(1, 16'h0080);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0001) $display("FAIL overrun_w1c got %h want 0001", v);
        else passed++;
        checks++;
        if (interrupt !== 1'b1) $display("FAIL overrun_irq got %b want 1", interrupt);
        else passed++;
    endtask

    task automatic test_collision();
        logic [15:0] v;
        do_reset();
        wr_reg(2, 16'h0001);
        wr_reg(0, 16'h0001);
        pulse_tick();
        wr_reg(1, 16'h0001);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0001) $display("FAIL collide_set_wins got %h want 0001", v);
        else passed++;
        wr_reg(1, 16'h0001);
        cyc(4);
        pulse_tick();
        wr_reg(2, 16'h0001);
        cyc(6);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0) $display("FAIL collide_write_wins got %h want 0000", v);
        else passed++;
        pulse_tick();
        cyc(6);
        rd_reg(1, v);
        checks++;
        if (v !== 16'h0001) $display("FAIL collide_next_fire got %h want 0001", v);
        else passed++;
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        logic [15:0] exp;
        do_reset();
        wr_reg(6, 16'h0001);
        rd_reg(6, v);
`ifdef REFLET_ALARM_ONESHOT_EN
        exp = 16'h0001;
`else
        exp = 16'h0000;
`endif
        checks++;
        if (v !== exp) $display("FAIL oneshot_reg got %h want %h", v, exp);
        else passed++;
        wr_reg(2, 16'h0002);
        wr_reg(0, 16'h0001);
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            cyc(6);
            rd_reg(1, v);
`ifdef REFLET_ALARM_ONESHOT_EN
            exp = (k == 2) ? 16'h0001 : 16'h0000;
`else
            exp = (k % 2 == 0) ? 16'h0001 : 16'h0000;
`endif
            checks++;
            if (v !== exp) $display("FAIL oneshot_status tick=%0d got %h want %h", k, v, exp);
            else passed++;
            wr_reg(1, 16'h0001);
        end
        rd_reg(0, v);
`ifdef REFLET_ALARM_ONESHOT_EN
        exp = 16'h0000;
`else
        exp = 16'h0001;
`endif
        checks++;
        if (v !== exp) $display("FAIL oneshot_ctrl got %h want %h", v, exp);
        else passed++;
    endtask

    task automatic test_decode();
        logic [15:0] v;
        do_reset();
        wr_reg(3, 16'hFF5A);
        rd_reg(3, v);
        checks++;
        if (v !== 16'h005A) $display("FAIL decode_zero_ext got %h want 005A", v);
        else passed++;
        addr = BASE + 16'd3;
        enable = 1'b0;
        #1;
        checks++;
        if (data_out !== 16'h0) $display("FAIL decode_enable_low got %h want 0000", data_out);
        else passed++;
        wr_reg(7, 16'h00FF);
        rd_reg(7, v);
        checks++;
        if (v !== 16'h0) $display("FAIL decode_off7 got %h want 0000", v);
        else passed++;
        addr = BASE - 16'd1;
        enable = 1'b1;
        #1;
        checks++;
        if (data_out !== 16'h0) $display("FAIL decode_below_base got %h want 0000", data_out);
        else passed++;
        enable = 1'b0;
        rd_reg(0, v);
        checks++;
        if (v !== 16'h0) $display("FAIL decode_ctrl_untouched got %h want 0000", v);
        else passed++;
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] v;
        do_reset();
        wr_reg(2, 16'h0001);
        wr_reg(3, 16'h0005);
        wr_reg(0, 16'h0003);
        pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int o = 0; o < 6; o++) begin
            rd_reg(o, v);
            checks++;
            if (v !== 16'h0) $display("FAIL midscan_read off=%0d got %h want 0000", o, v);
            else passed++;
        end
        cyc(3);
        checks++;
        if (interrupt !== 1'b0) $display("FAIL midscan_irq got %b want 0", interrupt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_multi();
        test_back_to_back();
        test_overrun();
        test_collision();
        test_oneshot();
        test_decode();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
